// File: rtl/access_trace_writer_if.sv
// Record-in / character-out handshake bundle for access_trace_writer.
// master: the side that offers records and sinks characters.
// slave : the trace writer itself.
interface access_trace_writer_if;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_address;
  logic        in_operation_bit;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_char;
  logic        out_last;

  modport master (
    output in_valid, in_address, in_operation_bit, out_ready,
    input  in_ready, out_valid, out_char, out_last
  );

  modport slave (
    input  in_valid, in_address, in_operation_bit, out_ready,
    output in_ready, out_valid, out_char, out_last
  );
endinterface

// File: rtl/access_trace_writer.sv
// access_trace_writer: turns each accepted memory-access record into one
// 9-character ASCII trace line "0x<op><5 hex digits>\n", one character per
// output handshake. After MAX_LINES lines the block parks in DONE until reset.
// Optional feature: define TRACE_LINE_COUNT_EN to add the saturating
// line_count[15:0] output port.
module access_trace_writer #(
  parameter int MAX_LINES = 524
) (
  input  logic                    clk,
  input  logic                    rst_n,
  access_trace_writer_if.slave    bus,
  output logic                    done
`ifdef TRACE_LINE_COUNT_EN
  ,
  output logic [15:0]             line_count
`endif
);

  localparam int CNT_W = (MAX_LINES > 1) ? $clog2(MAX_LINES + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_LINES);
  localparam logic [3:0] LAST_IDX = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [CNT_W-1:0] lines_q, lines_d;
  logic [19:0]      addr_q, addr_d;
  logic             op_q, op_d;
  logic             line_done;
  logic [7:0]       char_sel;

  // Lowercase hex digit for one nibble.
  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h57 + {4'h0, nib};
  endfunction

  // Last character of the current line is being taken by the sink.
  assign line_done = (state_q == ST_EMIT) && bus.out_ready && (idx_q == LAST_IDX);

  // State, character index, line counter and captured record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      lines_q <= '0;
      addr_q  <= 20'h00000;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lines_q <= lines_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    lines_d      = lines_q;
    addr_d       = addr_q;
    op_d         = op_q;
    bus.in_ready = 1'b0;
    bus.out_valid = 1'b0;
    done         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          // Record is frozen here; later input changes cannot affect the line.
          addr_d  = bus.in_address;
          op_d    = bus.in_operation_bit;
          idx_d   = 4'd0;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = 4'd0;
            lines_d = lines_q + 1'b1;
            state_d = (lines_d == LAST_CNT) ? ST_DONE : ST_IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Character for the current index; op char is '1' for read, '0' for write.
  always_comb begin
    char_sel = 8'h00;
    case (idx_q)
      4'd0:    char_sel = 8'h30;
      4'd1:    char_sel = 8'h78;
      4'd2:    char_sel = op_q ? 8'h30 : 8'h31;
      4'd3:    char_sel = hex_char(addr_q[19:16]);
      4'd4:    char_sel = hex_char(addr_q[15:12]);
      4'd5:    char_sel = hex_char(addr_q[11:8]);
      4'd6:    char_sel = hex_char(addr_q[7:4]);
      4'd7:    char_sel = hex_char(addr_q[3:0]);
      4'd8:    char_sel = 8'h0a;
      default: char_sel = 8'h00;
    endcase
  end

  // Character outputs are zero whenever no character is on offer.
  always_comb begin
    bus.out_char = (state_q == ST_EMIT) ? char_sel : 8'h00;
    bus.out_last = (state_q == ST_EMIT) && (idx_q == LAST_IDX);
  end

`ifdef TRACE_LINE_COUNT_EN
  logic [15:0] lc_q, lc_d;

  // Completed-line count, saturating at all ones.
  always_comb begin
    lc_d = lc_q;
    if (line_done && (lc_q != 16'hffff)) begin
      lc_d = lc_q + 16'd1;
    end
  end

  // Line count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lc_q <= 16'h0000;
    end else begin
      lc_q <= lc_d;
    end
  end

  assign line_count = lc_q;
`else
  // line_done is only consumed by the optional line counter.
  logic unused_line_done;
  assign unused_line_done = line_done;
`endif

endmodule

// File: tb/tb_access_trace_writer.sv
// Testbench for access_trace_writer: scoreboarded character stream on two
// instances (default MAX_LINES and MAX_LINES=2).
module tb_access_trace_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic done_a, done_b;

  access_trace_writer_if ifa ();
  access_trace_writer_if ifb ();

`ifdef TRACE_LINE_COUNT_EN
  logic [15:0] lc_a, lc_b;
`endif

  access_trace_writer dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (ifa),
    .done      (done_a)
`ifdef TRACE_LINE_COUNT_EN
    ,
    .line_count(lc_a)
`endif
  );

  access_trace_writer #(.MAX_LINES(2)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (ifb),
    .done      (done_b)
`ifdef TRACE_LINE_COUNT_EN
    ,
    .line_count(lc_b)
`endif
  );

  typedef struct packed {
    logic [7:0] ch;
    logic       last;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   chars_a  = 0;
  int   chars_b  = 0;
  bit   rand_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h61 + {4'h0, n} - 8'd10;
  endfunction

  // Expected 9 characters of one trace line.
  task automatic push_line(input bit which, input logic [19:0] a, input logic op);
    logic [7:0] c [9];
    exp_t e;
    c[0] = 8'h30;
    c[1] = 8'h78;
    c[2] = op ? 8'h30 : 8'h31;
    for (int i = 0; i < 5; i++) c[3+i] = hexc(a[19-4*i -: 4]);
    c[8] = 8'h0a;
    for (int i = 0; i < 9; i++) begin
      e.ch   = c[i];
      e.last = (i == 8);
      if (which) qb.push_back(e);
      else qa.push_back(e);
    end
  endtask

  // Offer one record; returns whether it was accepted within the bound.
  task automatic offer(input bit which, input logic [19:0] a, input logic op, output bit accepted);
    accepted = 1'b0;
    @(negedge clk);
    if (which) begin
      ifb.in_valid = 1'b1; ifb.in_address = a; ifb.in_operation_bit = op;
    end else begin
      ifa.in_valid = 1'b1; ifa.in_address = a; ifa.in_operation_bit = op;
    end
    for (int i = 0; i < 60; i++) begin
      if (which ? ifb.in_ready : ifa.in_ready) begin
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (accepted) push_line(which, a, op);
    @(posedge clk);
    #1;
    // Scramble inputs after capture; the line must not change.
    if (which) begin
      ifb.in_valid = 1'b0; ifb.in_address = ~a; ifb.in_operation_bit = ~op;
    end else begin
      ifa.in_valid = 1'b0; ifa.in_address = ~a; ifa.in_operation_bit = ~op;
    end
    if (accepted) begin
      check(which ? "b_valid_after_accept" : "a_valid_after_accept",
            32'(which ? ifb.out_valid : ifa.out_valid), 32'd1);
      check(which ? "b_first_char" : "a_first_char",
            32'(which ? ifb.out_char : ifa.out_char), 32'h30);
    end
  endtask

  task automatic wait_drain(input bit which);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if ((which ? qb.size() : qa.size()) == 0 &&
          !(which ? ifb.out_valid : ifa.out_valid)) break;
    end
    check(which ? "b_drained" : "a_drained", 32'(which ? qb.size() : qa.size()), 32'd0);
  endtask

  // Sink driver and scoreboard for instance A, with stall-stability checks.
  bit         stall_a = 1'b0;
  logic [7:0] stall_ch;
  logic       stall_last;
  always @(negedge clk) begin
    exp_t e;
    ifa.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!rst_n) begin
      stall_a = 1'b0;
    end else begin
      if (stall_a) begin
        check("a_stall_valid", 32'(ifa.out_valid), 32'd1);
        check("a_stall_char", 32'(ifa.out_char), 32'(stall_ch));
        check("a_stall_last", 32'(ifa.out_last), 32'(stall_last));
      end
      if (ifa.out_valid && ifa.out_ready) begin
        n_checks++;
        assert (qa.size() != 0) else begin
          n_fail++;
          $error("FAIL a_unexpected_char: observed %0h expected none", ifa.out_char);
        end
        if (qa.size() != 0) begin
          e = qa.pop_front();
          check("a_char", 32'(ifa.out_char), 32'(e.ch));
          check("a_last", 32'(ifa.out_last), 32'(e.last));
        end
        chars_a++;
        stall_a = 1'b0;
      end else begin
        stall_a    = ifa.out_valid;
        stall_ch   = ifa.out_char;
        stall_last = ifa.out_last;
      end
    end
  end

  // Scoreboard for instance B (sink always ready).
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ifb.out_valid && ifb.out_ready) begin
      n_checks++;
      assert (qb.size() != 0) else begin
        n_fail++;
        $error("FAIL b_unexpected_char: observed %0h expected none", ifb.out_char);
      end
      if (qb.size() != 0) begin
        e = qb.pop_front();
        check("b_char", 32'(ifb.out_char), 32'(e.ch));
        check("b_last", 32'(ifb.out_last), 32'(e.last));
      end
      chars_b++;
    end
  end

  initial begin
    bit acc;
    int cnt;
    int base;

    rst_n = 1'b0;
    ifa.in_valid = 1'b1; ifa.in_address = 20'h12345; ifa.in_operation_bit = 1'b0;
    ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.in_address = 20'h0; ifb.in_operation_bit = 1'b0;
    ifb.out_ready = 1'b1;

    // Reset values, with a record offered during reset that must be ignored.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(ifa.in_ready), 32'd1);
    check("rst_out_valid", 32'(ifa.out_valid), 32'd0);
    check("rst_out_char", 32'(ifa.out_char), 32'h00);
    check("rst_out_last", 32'(ifa.out_last), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
`ifdef TRACE_LINE_COUNT_EN
    check("rst_line_count", 32'(lc_a), 32'd0);
`endif
    @(negedge clk);
    ifa.in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_idle", 32'(ifa.in_ready), 32'd1);

    // Basic line and its 10-cycle turnaround.
    offer(1'b0, 20'h1a2b3, 1'b0, acc);
    check("accept_1a2b3", 32'(acc), 32'd1);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ifa.in_ready) break;
      cnt++;
    end
    check("line_busy_cycles", 32'(cnt), 32'd9);
    wait_drain(1'b0);

    // Boundary addresses and both op values.
    offer(1'b0, 20'hfffff, 1'b1, acc);
    check("accept_fffff", 32'(acc), 32'd1);
    offer(1'b0, 20'h00000, 1'b0, acc);
    check("accept_00000", 32'(acc), 32'd1);
    wait_drain(1'b0);

    // Random sink back-pressure.
    rand_ready = 1'b1;
    offer(1'b0, 20'h5c9e7, 1'b1, acc);
    check("accept_5c9e7", 32'(acc), 32'd1);
    wait_drain(1'b0);
    rand_ready = 1'b0;

    // Reset after the 4th character of a line.
    base = chars_a;
    offer(1'b0, 20'h13579, 1'b0, acc);
    check("accept_13579", 32'(acc), 32'd1);
    for (int i = 0; i < 60; i++) begin
      if (chars_a >= base + 4) break;
      @(posedge clk);
      #1;
    end
    check("chars_before_reset", 32'(chars_a - base), 32'd4);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(ifa.in_ready), 32'd1);
    check("midrst_out_valid", 32'(ifa.out_valid), 32'd0);
    check("midrst_out_char", 32'(ifa.out_char), 32'h00);
    check("midrst_out_last", 32'(ifa.out_last), 32'd0);
`ifdef TRACE_LINE_COUNT_EN
    check("midrst_line_count", 32'(lc_a), 32'd0);
`endif
    qa.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Three full lines after reset.
    offer(1'b0, 20'h00abc, 1'b0, acc);
    check("accept_00abc", 32'(acc), 32'd1);
    offer(1'b0, 20'h7d0e4, 1'b1, acc);
    check("accept_7d0e4", 32'(acc), 32'd1);
    offer(1'b0, 20'hbeef0, 1'b0, acc);
    check("accept_beef0", 32'(acc), 32'd1);
    wait_drain(1'b0);
`ifdef TRACE_LINE_COUNT_EN
    check("line_count_3", 32'(lc_a), 32'd3);
`endif
    check("a_not_done", 32'(done_a), 32'd0);

    // MAX_LINES=2 instance: third record is never accepted.
    offer(1'b1, 20'h0f00d, 1'b0, acc);
    check("b_accept_1", 32'(acc), 32'd1);
    offer(1'b1, 20'hc0ffe, 1'b1, acc);
    check("b_accept_2", 32'(acc), 32'd1);
    offer(1'b1, 20'h77777, 1'b0, acc);
    check("b_accept_3", 32'(acc), 32'd0);
    wait_drain(1'b1);
    check("b_done", 32'(done_b), 32'd1);
    check("b_in_ready_done", 32'(ifb.in_ready), 32'd0);
    check("b_out_valid_done", 32'(ifb.out_valid), 32'd0);
    check("b_chars", 32'(chars_b), 32'd18);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/access_trace_writer.md
ACCESS_TRACE_WRITER -- requirements
Module: access_trace_writer

Interface
REQ-001 SHALL have parameter MAX_LINES, default 524, number of trace lines emitted before the block enters DONE.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  access record offered.
REQ-005 SHALL have port in_ready  output  1  record accepted when in_valid and in_ready are both 1 at a rising edge.
REQ-006 SHALL have port in_address  input  20  access address.
REQ-007 SHALL have port in_operation_bit  input  1  0 = read, 1 = write.
REQ-008 SHALL have port out_valid  output  1  out_char holds a valid character.
REQ-009 SHALL have port out_ready  input  1  sink accepts out_char when out_valid and out_ready are both 1 at a rising edge.
REQ-010 SHALL have port out_char  output  8  ASCII character.
REQ-011 SHALL have port out_last  output  1  high with the final character of a line.
REQ-012 SHALL have port done  output  1  MAX_LINES lines have been emitted.

Function
REQ-013 SHALL serialize each accepted record as exactly 9 characters: '0', 'x', op char, 5 lowercase hex digits of in_address MSB-nibble first, '\n' (0x0A).
REQ-014 SHALL encode the op char as '1' when in_operation_bit=0 and '0' when in_operation_bit=1.
REQ-015 SHALL emit hex digits 0-9 as 0x30-0x39 and a-f as 0x61-0x66; uppercase is never produced.
REQ-016 SHALL implement states IDLE, EMIT and DONE.
REQ-017 SHALL drive in_ready=1 only in IDLE, and out_valid=1 only in EMIT.
REQ-018 SHALL, on acceptance in IDLE, capture address and op bit into an internal register, clear the character index to 0, and enter EMIT; out_valid is 1 in the cycle after acceptance.
REQ-019 SHALL advance the character index by one per out handshake and hold out_char/out_last stable while out_valid=1 and out_ready=0.
REQ-020 SHALL assert out_last only at index 8 ('\n').
REQ-021 SHALL, on the index-8 handshake, increment the line counter and go to IDLE, or to DONE if the counter reaches MAX_LINES.
REQ-022 SHALL make DONE absorbing until reset: done=1, in_ready=0, out_valid=0, and further in_valid is ignored.
REQ-023 SHALL ignore in_address/in_operation_bit changes after capture; the line in progress always reflects the captured values.
REQ-024 SHALL provide one-line throughput of 10 cycles with out_ready held at 1: 1 accept cycle and 9 character cycles.

Reset
REQ-025 SHALL, with rst_n=0, immediately force IDLE, index 0, line counter 0, in_ready=1, out_valid=0, out_last=0, out_char=0x00, done=0.
REQ-026 SHALL abandon any partially emitted line on reset, so the next line starts at '0'.
REQ-027 SHALL leave IDLE no earlier than the first rising edge after rst_n returns to 1.

Configuration
REQ-028 SHALL, when macro TRACE_LINE_COUNT_EN is defined, add output port line_count[15:0] equal to the number of completed lines, reset to 0, updated on the index-8 handshake, and saturating at 16'hffff.
REQ-029 SHALL, when TRACE_LINE_COUNT_EN is undefined, omit line_count; all other behaviour is identical.

Verification
REQ-030 SHALL cover: address 20'h1a2b3 with op 0 and out_ready=1 -> chars "0x11a2b3\n" on consecutive cycles, out_last only on 0x0A, in_ready back to 1 ten cycles after acceptance.
REQ-031 SHALL cover: address 20'hfffff with op 1 -> "0x0fffff\n"; address 20'h00000 with op 0 -> "0x100000\n".
REQ-032 SHALL cover: out_ready toggled pseudo-randomly during a line -> out_char is stable while stalled and no character is dropped or duplicated.
REQ-033 SHALL cover: rst_n pulsed low after the 4th character -> outputs take reset values immediately, and the next accepted record emits from '0'.
REQ-034 SHALL cover: MAX_LINES=2 with three records offered -> two lines emitted, done=1, third record never accepted (in_ready=0).
REQ-035 SHALL cover: with TRACE_LINE_COUNT_EN defined, 3 lines emitted -> line_count=3 after the third '\n' handshake.
